// File: rtl/rgb_mixer_pkg.sv
// Shared definitions for the RGB mixer: quadrature pin states, decoded
// transition directions and the detent size of the rotary encoders.
package rgb_mixer_pkg;

  typedef enum logic [1:0] {
    AB_00 = 2'b00,
    AB_01 = 2'b01,
    AB_10 = 2'b10,
    AB_11 = 2'b11
  } ab_state_t;

  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_CW   = 2'd1,
    DIR_CCW  = 2'd2,
    DIR_ERR  = 2'd3
  } dir_t;

  localparam int unsigned QUARTERS_PER_DETENT = 4;

  // Gray-code walk 00->01->11->10->00 is clockwise; a double-bit change
  // cannot be attributed to either direction.
  function automatic dir_t decode_dir(input ab_state_t prev, input ab_state_t cur);
    logic [1:0] diff;
    ab_state_t  cw_next;
    dir_t       dir;
    diff = prev ^ cur;
    case (prev)
      AB_00:   cw_next = AB_01;
      AB_01:   cw_next = AB_11;
      AB_11:   cw_next = AB_10;
      default: cw_next = AB_00;
    endcase
    if (diff == 2'b00) begin
      dir = DIR_NONE;
    end else if (diff == 2'b11) begin
      dir = DIR_ERR;
    end else if (cur == cw_next) begin
      dir = DIR_CW;
    end else begin
      dir = DIR_CCW;
    end
    return dir;
  endfunction

endpackage

// File: rtl/debounce_sync.sv
// Two-flop synchroniser plus debounce filter for one idle-high encoder pin.
module debounce_sync #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic deb
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      deb   <= 1'b1;
      cnt   <= '0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
      // accept the new value on the DEBOUNCE_CYCLES-th consecutive differing sample
      if (sync2 == deb) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        deb <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/encoder_level.sv
// Quadrature rotary encoder to PWM brightness level: debounced x4 decode,
// one level step per detent, with saturating or wrapping arithmetic.
module encoder_level
  import rgb_mixer_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned STEP            = 1,
  parameter int unsigned SATURATE        = 1,
  parameter int unsigned RESET_LEVEL     = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enc_a,
  input  logic             enc_b,
  input  logic             clear,
  output logic [WIDTH-1:0] level,
  output logic             step_up,
  output logic             step_dn,
  output logic             err
);

  localparam int Q_LIMIT = int'(QUARTERS_PER_DETENT) - 1;
  localparam logic signed [2:0] Q_TOP  = 3'(Q_LIMIT);
  localparam logic signed [2:0] Q_BOT  = 3'(-Q_LIMIT);
  localparam logic [WIDTH-1:0]  LVL_RST = WIDTH'(RESET_LEVEL);
  localparam logic [WIDTH:0]    STEP_W  = (WIDTH+1)'(STEP);

  logic                deb_a;
  logic                deb_b;
  ab_state_t           ab;
  ab_state_t           prev_ab;
  dir_t                dir;
  logic signed [2:0]   q;
  logic signed [2:0]   q_next;
  logic [WIDTH-1:0]    level_next;
  logic [WIDTH-1:0]    level_inc;
  logic [WIDTH-1:0]    level_dec;
  logic [WIDTH:0]      sum_up;
  logic [WIDTH:0]      diff_dn;
  logic                up_next;
  logic                dn_next;
  logic                err_next;

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (enc_a),
    .deb   (deb_a)
  );

  debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst_n (rst_n),
    .pin   (enc_b),
    .deb   (deb_b)
  );

  assign ab  = ab_state_t'({deb_a, deb_b});
  assign dir = decode_dir(prev_ab, ab);

  // One extra bit exposes carry/borrow for the clamp decision.
  assign sum_up  = {1'b0, level} + STEP_W;
  assign diff_dn = {1'b0, level} - STEP_W;

  always_comb begin
    level_inc = sum_up[WIDTH-1:0];
    level_dec = diff_dn[WIDTH-1:0];
    if (SATURATE != 0) begin
      if (sum_up[WIDTH])  level_inc = '1;
      if (diff_dn[WIDTH]) level_dec = '0;
    end
  end

  always_comb begin
    level_next = level;
    q_next     = q;
    up_next    = 1'b0;
    dn_next    = 1'b0;
    err_next   = (dir == DIR_ERR);
    case (dir)
      DIR_CW: begin
        if (q == Q_TOP) begin
          q_next     = '0;
          level_next = level_inc;
          up_next    = 1'b1;
        end else begin
          q_next = q + 3'sd1;
        end
      end
      DIR_CCW: begin
        if (q == Q_BOT) begin
          q_next     = '0;
          level_next = level_dec;
          dn_next    = 1'b1;
        end else begin
          q_next = q - 3'sd1;
        end
      end
      default: ;
    endcase
    if (clear) begin
      level_next = LVL_RST;
      q_next     = '0;
      up_next    = 1'b0;
      dn_next    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_ab <= AB_11;
      q       <= '0;
      level   <= LVL_RST;
      step_up <= 1'b0;
      step_dn <= 1'b0;
      err     <= 1'b0;
    end else begin
      prev_ab <= ab;
      q       <= q_next;
      level   <= level_next;
      step_up <= up_next;
      step_dn <= dn_next;
      err     <= err_next;
    end
  end

  a_one_step_dir: assert property (@(posedge clk) disable iff (!rst_n) !(step_up && step_dn));

endmodule

// File: tb/tb_encoder_level.sv
// Scoreboard bench for encoder_level: three instances (saturating STEP=1,
// wrapping STEP=1, saturating STEP=5 from 253) share the encoder pins.
module tb_encoder_level;

  localparam int unsigned D    = 4;
  localparam int unsigned LAT  = D + 3;   // negedge drive -> negedge where output is seen
  localparam int unsigned HOLD = 10;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic enc_a = 1'b1;
  logic enc_b = 1'b1;
  logic clear = 1'b0;

  logic [7:0] lvl [3];
  logic [2:0] up;
  logic [2:0] dn;
  logic [2:0] er;

  int unsigned cyc = 0;
  int unsigned drive_cyc = 0;
  int tests = 0;
  int fails = 0;

  typedef struct {
    int          inst;
    logic        u;
    logic        d;
    logic        e;
    logic [7:0]  lv;
    int unsigned at;
  } exp_t;

  exp_t sb[$];
  exp_t cur;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(1), .SATURATE(1), .RESET_LEVEL(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .level(lvl[0]), .step_up(up[0]), .step_dn(dn[0]), .err(er[0])
  );

  encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(1), .SATURATE(0), .RESET_LEVEL(0)) u_wrap (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .level(lvl[1]), .step_up(up[1]), .step_dn(dn[1]), .err(er[1])
  );

  encoder_level #(.WIDTH(8), .DEBOUNCE_CYCLES(D), .STEP(5), .SATURATE(1), .RESET_LEVEL(253)) u_big (
    .clk(clk), .rst_n(rst_n), .enc_a(enc_a), .enc_b(enc_b), .clear(clear),
    .level(lvl[2]), .step_up(up[2]), .step_dn(dn[2]), .err(er[2])
  );

  // Monitor: every pulse on any instance must match the next queued event.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 3; i++) begin
        if (up[i] || dn[i] || er[i]) begin
          tests++;
          if (sb.size() == 0) begin
            fails++;
            $display("FAIL unexpected_pulse inst=%0d up=%b dn=%b err=%b level=%0d cycle=%0d",
                     i, up[i], dn[i], er[i], lvl[i], cyc);
          end else begin
            cur = sb.pop_front();
            if (cur.inst != i || cur.u !== up[i] || cur.d !== dn[i] || cur.e !== er[i] ||
                cur.lv !== lvl[i] || cur.at != cyc) begin
              fails++;
              $display("FAIL event: got inst=%0d up=%b dn=%b err=%b level=%0d cycle=%0d, want inst=%0d up=%b dn=%b err=%b level=%0d cycle=%0d",
                       i, up[i], dn[i], er[i], lvl[i], cyc,
                       cur.inst, cur.u, cur.d, cur.e, cur.lv, cur.at);
            end
          end
        end
      end
    end
  end

  task automatic drive_ab(input logic [1:0] v);
    @(negedge clk);
    {enc_a, enc_b} = v;
    drive_cyc = cyc;
  endtask

  task automatic settle();
    repeat (HOLD - 1) @(negedge clk);
  endtask

  task automatic push3(input logic u, input logic d, input logic e,
                       input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
    sb.push_back('{0, u, d, e, l0, drive_cyc + LAT});
    sb.push_back('{1, u, d, e, l1, drive_cyc + LAT});
    sb.push_back('{2, u, d, e, l2, drive_cyc + LAT});
  endtask

  task automatic check_levels(input string name, input logic [7:0] a,
                              input logic [7:0] b, input logic [7:0] c);
    tests++;
    if (lvl[0] !== a || lvl[1] !== b || lvl[2] !== c) begin
      fails++;
      $display("FAIL %s: level got %0d/%0d/%0d want %0d/%0d/%0d",
               name, lvl[0], lvl[1], lvl[2], a, b, c);
    end
  endtask

  task automatic check_quiet(input string name);
    tests++;
    if (up !== 3'b000 || dn !== 3'b000 || er !== 3'b000) begin
      fails++;
      $display("FAIL %s: pulses got up=%b dn=%b err=%b want all 000", name, up, dn, er);
    end
  endtask

  // Full detent from AB=11 and back; the step lands after the final edge.
  task automatic detent(input logic cw, input logic [7:0] l0, input logic [7:0] l1,
                        input logic [7:0] l2);
    if (cw) begin
      drive_ab(2'b10); settle();
      drive_ab(2'b00); settle();
      drive_ab(2'b01); settle();
    end else begin
      drive_ab(2'b01); settle();
      drive_ab(2'b00); settle();
      drive_ab(2'b10); settle();
    end
    drive_ab(2'b11);
    push3(cw, !cw, 1'b0, l0, l1, l2);
    settle();
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_levels("reset_level", 8'd0, 8'd0, 8'd253);
    check_quiet("reset_pulses");
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    detent(1'b1, 8'd1, 8'd1, 8'd255);          // 253+5 clamps to 255
    check_levels("cw_detent", 8'd1, 8'd1, 8'd255);

    @(negedge clk); enc_a = 1'b0;              // 3-cycle glitch on A
    repeat (3) @(negedge clk); enc_a = 1'b1;
    settle();
    check_levels("bounce", 8'd1, 8'd1, 8'd255);

    detent(1'b0, 8'd0, 8'd0, 8'd250);
    detent(1'b0, 8'd0, 8'd255, 8'd245);        // clamp at 0 vs wrap to 255
    detent(1'b1, 8'd1, 8'd0, 8'd250);          // wrap 255 -> 0
    check_levels("wrap_up", 8'd1, 8'd0, 8'd250);

    drive_ab(2'b00); push3(1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 8'd250); settle();
    drive_ab(2'b11); push3(1'b0, 1'b0, 1'b1, 8'd1, 8'd0, 8'd250); settle();
    check_levels("illegal_jump", 8'd1, 8'd0, 8'd250);

    drive_ab(2'b10); settle();
    drive_ab(2'b00); settle();
    drive_ab(2'b10); settle();
    drive_ab(2'b11); settle();
    check_levels("half_detent_reverse", 8'd1, 8'd0, 8'd250);

    // clear lands on the same edge as the detent completion
    drive_ab(2'b10); settle();
    drive_ab(2'b00); settle();
    drive_ab(2'b01); settle();
    drive_ab(2'b11);
    repeat (LAT - 1) @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    settle();
    check_levels("clear_vs_detent", 8'd0, 8'd0, 8'd253);

    detent(1'b1, 8'd1, 8'd1, 8'd255);
    drive_ab(2'b10); settle();                 // one quarter in flight
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_levels("async_reset", 8'd0, 8'd0, 8'd253);
    check_quiet("async_reset_pulses");
    @(negedge clk);
    rst_n = 1'b1;
    settle();
    // restart from AB=11: pins already at 10 count as the first quarter
    drive_ab(2'b00); settle();
    drive_ab(2'b01); settle();
    drive_ab(2'b11);
    push3(1'b1, 1'b0, 1'b0, 8'd1, 8'd1, 8'd255);
    settle();
    check_levels("after_reset_detent", 8'd1, 8'd1, 8'd255);

    repeat (20) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL missing_events: %0d still queued, want 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
